// File: rtl/trap_ctrl_if.sv
// rtl/trap_ctrl_if.sv - commit-stage trap request and CSR/fetch response bundle
interface trap_ctrl_if;
    logic        exc_req;
    logic [31:0] exc_req_pc;
    logic [4:0]  exc_req_cause;
    logic        mret_req;
    logic [31:0] epc_in;
    logic        req_ready;
    logic        exception_sig;
    logic [31:0] exception_pc;
    logic [4:0]  exception_cause;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output exc_req, exc_req_pc, exc_req_cause, mret_req, epc_in,
        input  req_ready, exception_sig, exception_pc, exception_cause,
               flush, redirect_valid, redirect_pc
    );

    modport slave (
        input  exc_req, exc_req_pc, exc_req_cause, mret_req, epc_in,
        output req_ready, exception_sig, exception_pc, exception_cause,
               flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - exception/mret sequencer: record, flush, redirect fetch
// Optional macro TRAP_VECTORED_EN: exception redirect = TRAP_VECTOR + (cause << 2).
module trap_ctrl #(
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int          FLUSH_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    trap_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RECORD, DRAIN, REDIRECT} state_t;

    // Remaining flush cycles after the current one; RECORD counts as a flush cycle.
    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] target;
    logic [31:0] exc_target;

`ifdef TRAP_VECTORED_EN
    assign exc_target = TRAP_VECTOR + {25'd0, bus.exc_req_cause, 2'b00};
`else
    assign exc_target = TRAP_VECTOR;
`endif

    assign bus.req_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            cnt                 <= 4'd0;
            target              <= 32'd0;
            bus.exception_sig   <= 1'b0;
            bus.exception_pc    <= 32'd0;
            bus.exception_cause <= 5'd0;
            bus.flush           <= 1'b0;
            bus.redirect_valid  <= 1'b0;
            bus.redirect_pc     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    // Exception has priority; a simultaneous mret stays pending.
                    if (bus.exc_req) begin
                        state               <= RECORD;
                        cnt                 <= CNT_INIT;
                        target              <= exc_target;
                        bus.exception_sig   <= 1'b1;
                        bus.exception_pc    <= bus.exc_req_pc;
                        bus.exception_cause <= bus.exc_req_cause;
                        bus.flush           <= 1'b1;
                    end else if (bus.mret_req) begin
                        state     <= DRAIN;
                        cnt       <= CNT_INIT;
                        target    <= bus.epc_in;
                        bus.flush <= 1'b1;
                    end
                end
                RECORD: begin
                    bus.exception_sig <= 1'b0;
                    if (cnt == 4'd0) begin
                        state              <= REDIRECT;
                        bus.flush          <= 1'b0;
                        bus.redirect_valid <= 1'b1;
                        bus.redirect_pc    <= target;
                    end else begin
                        state <= DRAIN;
                        cnt   <= cnt - 4'd1;
                    end
                end
                DRAIN: begin
                    if (cnt == 4'd0) begin
                        state              <= REDIRECT;
                        bus.flush          <= 1'b0;
                        bus.redirect_valid <= 1'b1;
                        bus.redirect_pc    <= target;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                REDIRECT: begin
                    state              <= IDLE;
                    bus.redirect_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 The block SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, the trap handler base address.
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 3, the number of cycles flush is held; legal range 1..15.
REQ-003 The block SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port exc_req  input  1  commit stage reports an exception.
REQ-006 The block SHALL have port exc_req_pc  input  32  PC of the excepting instruction.
REQ-007 The block SHALL have port exc_req_cause  input  5  exception cause code.
REQ-008 The block SHALL have port mret_req  input  1  commit stage reports a trap return.
REQ-009 The block SHALL have port epc_in  input  32  current EPC value read from the CSR block.
REQ-010 The block SHALL have port req_ready  output  1  high when a request is accepted this cycle.
REQ-011 The block SHALL have port exception_sig  output  1  one-cycle strobe telling the CSR block to record EPC and cause.
REQ-012 The block SHALL have port exception_pc  output  32  EPC value accompanying exception_sig.
REQ-013 The block SHALL have port exception_cause  output  5  cause accompanying exception_sig.
REQ-014 The block SHALL have port flush  output  1  squash all in-flight instructions.
REQ-015 The block SHALL have port redirect_valid  output  1  one-cycle strobe to load the fetch PC.
REQ-016 The block SHALL have port redirect_pc  output  32  new fetch PC.

Function
REQ-017 The FSM SHALL have states IDLE, RECORD, DRAIN and REDIRECT.
REQ-018 req_ready SHALL be 1 only in IDLE (combinational decode of the state).
REQ-019 A request SHALL be accepted only on an edge where it is asserted and req_ready=1; requests outside IDLE are ignored and the requester holds them.
REQ-020 On an exc_req accepted at edge N, the block SHALL latch exc_req_pc and exc_req_cause and enter RECORD.
REQ-021 In RECORD (cycle N+1), exception_sig SHALL be 1 with the latched pc/cause on exception_pc and exception_cause, and flush SHALL be 1.
REQ-022 On an mret_req accepted at edge N, the block SHALL latch epc_in and enter DRAIN directly; exception_sig SHALL stay 0.
REQ-023 flush SHALL be 1 in RECORD and DRAIN; the down-counter SHALL hold total flush cycles at exactly FLUSH_CYCLES (exception: cycles N+1..N+FLUSH_CYCLES; mret: cycles N+1..N+FLUSH_CYCLES).
REQ-024 With FLUSH_CYCLES=1, the exception path SHALL go RECORD->REDIRECT, skipping DRAIN.
REQ-025 REDIRECT SHALL last one cycle (cycle N+FLUSH_CYCLES+1) with redirect_valid=1 and flush=0, then return to IDLE.
REQ-026 On the exception path, redirect_pc SHALL be TRAP_VECTOR; on the mret path it SHALL be the latched epc_in.
REQ-027 When exc_req and mret_req are both asserted in IDLE, exc_req SHALL win and the mret SHALL NOT be consumed.
REQ-028 exception_pc, exception_cause and redirect_pc SHALL hold their last values when their strobes are 0.
REQ-029 All outputs except req_ready SHALL be registered.

Reset
REQ-030 rst SHALL force the FSM to IDLE and clear the counter, exception_sig, flush, redirect_valid, exception_pc, exception_cause and redirect_pc to 0, including when asserted mid-sequence.
REQ-031 req_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-032 With macro TRAP_VECTORED_EN defined, the exception-path redirect_pc SHALL be TRAP_VECTOR + (cause << 2), a 32-bit sum with wrap-around; the mret path is unchanged.
REQ-033 Without TRAP_VECTORED_EN, the exception-path redirect_pc SHALL be TRAP_VECTOR for every cause.

Verification
REQ-034 exc_req with pc=0x0000_0040 and cause=2 -> exception_sig=1 with 0x40/2 one cycle later, then flush for 3 cycles, then redirect_valid=1 with redirect_pc=0x100.
REQ-035 mret_req with epc_in=0x0000_0080 -> no exception_sig, flush for 3 cycles, then redirect_valid=1 with redirect_pc=0x80.
REQ-036 exc_req and mret_req in the same IDLE cycle -> only the exception sequence runs; mret is accepted later in IDLE.
REQ-037 exc_req held high from the RECORD through the DRAIN cycles -> no second acceptance until IDLE; the second exception is accepted on the first IDLE cycle.
REQ-038 rst asserted during DRAIN -> next cycle all outputs are 0 and req_ready=1; no redirect occurs.
REQ-039 With TRAP_VECTORED_EN defined, cause=5 -> redirect_pc=0x114.
